// File: rtl/shift_ctrl.sv
// shift_ctrl: accepts parallel words over valid/ready and serializes them LSB first with a sample strobe,
// an idle gap after each frame and a completed-frame counter. Define SHIFT_CTRL_PARITY_EN to append an even-parity bit.
module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             Shift_in,
  output logic             shift_en,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_GAP    = 2'd2
`ifdef SHIFT_CTRL_PARITY_EN
    , S_PARITY = 2'd3
`endif
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             shift_in_reg, shift_in_next;
  logic             shift_en_reg, shift_en_next;
  logic             frame_start_reg, frame_start_next;
  logic             frame_done_reg, frame_done_next;
  logic [7:0]       words_sent_reg, words_sent_next;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg       <= S_IDLE;
      bit_cnt_reg     <= '0;
      word_reg        <= '0;
      gap_cnt_reg     <= '0;
      shift_in_reg    <= 1'b0;
      shift_en_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      words_sent_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      word_reg        <= word_next;
      gap_cnt_reg     <= gap_cnt_next;
      shift_in_reg    <= shift_in_next;
      shift_en_reg    <= shift_en_next;
      frame_start_reg <= frame_start_next;
      frame_done_reg  <= frame_done_next;
      words_sent_reg  <= words_sent_next;
    end
  end

  // Serial outputs are registered, so each branch computes what the next cycle presents.
  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    word_next        = word_reg;
    gap_cnt_next     = gap_cnt_reg;
    shift_in_next    = 1'b0;
    shift_en_next    = 1'b0;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;
    words_sent_next  = words_sent_reg;

    case (state_reg)
      S_IDLE: begin
        if (data_valid) begin
          word_next        = data_in;
          bit_cnt_next     = '0;
          state_next       = S_SHIFT;
          shift_in_next    = data_in[0];
          shift_en_next    = 1'b1;
          frame_start_next = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bit_cnt_reg != LAST_BIT) begin
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          shift_in_next = word_reg[bit_cnt_next];
          shift_en_next = 1'b1;
`ifndef SHIFT_CTRL_PARITY_EN
          frame_done_next = (bit_cnt_next == LAST_BIT);
`endif
        end else begin
`ifdef SHIFT_CTRL_PARITY_EN
          state_next      = S_PARITY;
          shift_in_next   = ^word_reg;
          shift_en_next   = 1'b1;
          frame_done_next = 1'b1;
`else
          words_sent_next = words_sent_reg + 8'd1;
          if (GAP > 0) begin
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end else begin
            state_next = S_IDLE;
          end
`endif
        end
      end

`ifdef SHIFT_CTRL_PARITY_EN
      S_PARITY: begin
        words_sent_next = words_sent_reg + 8'd1;
        if (GAP > 0) begin
          state_next   = S_GAP;
          gap_cnt_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
`endif

      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Ready is gated by Reset directly so it drops in the same cycle the reset arrives.
  assign data_ready  = (state_reg == S_IDLE) && !Reset;
  assign busy        = (state_reg != S_IDLE);
  assign Shift_in    = shift_in_reg;
  assign shift_en    = shift_en_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign words_sent  = words_sent_reg;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl: main instance WIDTH=8/GAP=2 and a second instance with GAP=0.
// Expected values follow SHIFT_CTRL_PARITY_EN when the bench is built with that macro.
module tb_shift_ctrl;
  localparam int W = 8;
  localparam int G = 2;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, Shift_in, shift_en, frame_start, frame_done, busy;
  logic [7:0] words_sent;

  logic [7:0] d0_data_in = 8'h00;
  logic       d0_valid = 1'b0;
  logic       d0_ready, d0_shift_in, d0_shift_en, d0_start, d0_done, d0_busy;
  logic [7:0] d0_words;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  shift_ctrl #(.WIDTH(W), .GAP(G)) dut (
    .CLK(CLK), .Reset(Reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .Shift_in(Shift_in), .shift_en(shift_en),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .words_sent(words_sent)
  );

  shift_ctrl #(.WIDTH(W), .GAP(0)) dut0 (
    .CLK(CLK), .Reset(Reset), .data_in(d0_data_in), .data_valid(d0_valid),
    .data_ready(d0_ready), .Shift_in(d0_shift_in), .shift_en(d0_shift_en),
    .frame_start(d0_start), .frame_done(d0_done), .busy(d0_busy),
    .words_sent(d0_words)
  );

  // Entered at the negedge of the cycle holding bit 0; leaves one cycle after the last serial bit.
  task automatic check_frame(input logic [7:0] w, input logic [7:0] exp_ws, input int poke_at,
                             input logic [7:0] poke_data, input logic poke_valid, input string tag);
    logic exp_bit;
    for (int i = 0; i < W + P; i++) begin
      exp_bit = (i < W) ? w[i] : ^w;
      checks++;
      if (shift_en !== 1'b1 || Shift_in !== exp_bit || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s bit%0d: en=%b bit=%b busy=%b want en=1 bit=%b busy=1",
                 tag, i, shift_en, Shift_in, busy, exp_bit);
      end
      checks++;
      if (frame_start !== (i == 0) || frame_done !== (i == W + P - 1)) begin
        errors++;
        $display("FAIL %s strobes%0d: start=%b done=%b want start=%b done=%b",
                 tag, i, frame_start, frame_done, (i == 0), (i == W + P - 1));
      end
      if (i == W + P - 1) begin
        checks++;
        if (words_sent !== exp_ws - 8'd1) begin
          errors++;
          $display("FAIL %s count_before: got %0d want %0d", tag, words_sent, exp_ws - 8'd1);
        end
      end
      if (i == poke_at) begin
        data_in = poke_data;
        data_valid = poke_valid;
      end
      @(negedge CLK);
    end
    checks++;
    if (words_sent !== exp_ws || shift_en !== 1'b0) begin
      errors++;
      $display("FAIL %s count_after: got %0d en=%b want %0d en=0", tag, words_sent, shift_en, exp_ws);
    end
    $display("frame %s word=%h words_sent=%0d", tag, w, words_sent);
  endtask

  task automatic test_reset;
    @(negedge CLK);
    checks++;
    if (data_ready !== 1'b0 || busy !== 1'b0 || shift_en !== 1'b0 || Shift_in !== 1'b0 ||
        frame_start !== 1'b0 || frame_done !== 1'b0 || words_sent !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b en=%b bit=%b st=%b dn=%b ws=%0d want all 0",
               data_ready, busy, shift_en, Shift_in, frame_start, frame_done, words_sent);
    end
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (data_ready !== 1'b1 || busy !== 1'b0 || d0_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b rdy0=%b want 1 0 1", data_ready, busy, d0_ready);
    end
    $display("reset done");
  endtask

  task automatic test_basic;
    int cnt;
    data_in = 8'hA5;
    data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    check_frame(8'hA5, 8'd1, 2, 8'hFF, 1'b0, "basic_a5");
    cnt = W + P;
    while (!data_ready && cnt < 40) begin
      @(negedge CLK);
      cnt++;
    end
    checks++;
    if (cnt !== W + P + G) begin
      errors++;
      $display("FAIL basic_ready_return: got %0d cycles want %0d", cnt, W + P + G);
    end
  endtask

  task automatic test_back_to_back;
    int cnt, t1, t2;
    data_in = 8'h3C;
    data_valid = 1'b1;
    cnt = 0;
    while (!frame_start && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    t1 = cyc;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start1: got %b want 1", frame_start);
    end
    check_frame(8'h3C, 8'd2, 3, 8'hFF, 1'b1, "b2b_3c");
    cnt = 0;
    while (!frame_start && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    t2 = cyc;
    checks++;
    if (t2 - t1 !== 1 + W + P + G) begin
      errors++;
      $display("FAIL b2b_period: got %0d want %0d", t2 - t1, 1 + W + P + G);
    end
    check_frame(8'hFF, 8'd3, 0, 8'h00, 1'b0, "b2b_ff");
  endtask

  task automatic test_gap0;
    int cnt;
    d0_data_in = 8'h81;
    d0_valid = 1'b1;
    cnt = 0;
    while (!d0_start && cnt < 20) begin
      @(negedge CLK);
      cnt++;
    end
    for (int j = 0; j < 2 * (W + P) + 1; j++) begin
      checks++;
      if (d0_shift_en !== (j != W + P) || d0_ready !== (j == W + P) ||
          d0_start !== (j == 0 || j == W + P + 1)) begin
        errors++;
        $display("FAIL gap0_cycle%0d: en=%b rdy=%b st=%b want en=%b rdy=%b st=%b", j,
                 d0_shift_en, d0_ready, d0_start, (j != W + P), (j == W + P), (j == 0 || j == W + P + 1));
      end
      if (j == W + P + 1) d0_valid = 1'b0;
      @(negedge CLK);
    end
    checks++;
    if (d0_words !== 8'd2) begin
      errors++;
      $display("FAIL gap0_count: got %0d want 2", d0_words);
    end
    $display("gap0 frames words_sent=%0d", d0_words);
  endtask

  task automatic test_reset_mid;
    int cnt;
    data_in = 8'hA5;
    data_valid = 1'b1;
    cnt = 0;
    while (!frame_start && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    data_valid = 1'b0;
    repeat (4) @(negedge CLK);
    Reset = 1'b1;
    #1;
    checks++;
    if (Shift_in !== 1'b0 || shift_en !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0 ||
        busy !== 1'b0 || data_ready !== 1'b0 || words_sent !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: bit=%b en=%b st=%b dn=%b busy=%b rdy=%b ws=%0d want all 0",
               Shift_in, shift_en, frame_start, frame_done, busy, data_ready, words_sent);
    end
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b want 1", data_ready);
    end
    data_in = 8'h5A;
    data_valid = 1'b1;
    @(negedge CLK);
    data_valid = 1'b0;
    check_frame(8'h5A, 8'd1, -1, 8'h00, 1'b0, "post_reset_5a");
  endtask

  task automatic test_wrap;
    int n, guard;
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    data_in = 8'h55;
    data_valid = 1'b1;
    n = 0;
    guard = 0;
    while (n < 256 && guard < 4000) begin
      @(negedge CLK);
      guard++;
      if (frame_done) begin
        n++;
        if (n == 256) data_valid = 1'b0;
        @(negedge CLK);
        if (n == 255) begin
          checks++;
          if (words_sent !== 8'd255) begin
            errors++;
            $display("FAIL wrap_255: got %0d want 255", words_sent);
          end
        end
        if (n == 256) begin
          checks++;
          if (words_sent !== 8'd0) begin
            errors++;
            $display("FAIL wrap_256: got %0d want 0", words_sent);
          end
        end
      end
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL wrap_frames: got %0d want 256", n);
    end
    $display("wrap frames=%0d words_sent=%0d", n, words_sent);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
